// File: rtl/free_preg_list_mw_if.sv
`default_nettype none
//============================================================================
// Module      : free_preg_list_mw_if
// Description : Bundle of the rename-side and commit-side signals of the
//               multi-wide free physical-register list.
//               master : rename/commit logic (drives requests, frees,
//                        checkpoint controls)
//               slave  : free_preg_list_mw
//               Ports  : stall, alloc_req/grant/preg, free_vld/preg,
//                        ckpt_take/id/full/release/restore, restore_id,
//                        count, empty, err
// Revision    : 1.0 - initial release
//============================================================================
interface free_preg_list_mw_if #(
    parameter int NUM_PREGS = 128,
    parameter int ALLOC_W   = 2,
    parameter int FREE_W    = 2,
    parameter int NUM_CKPT  = 4
);
    localparam int PW = $clog2(NUM_PREGS);
    localparam int CW = $clog2(NUM_CKPT);

    logic                    stall;
    logic [ALLOC_W-1:0]      alloc_req;
    logic                    alloc_grant;
    logic [ALLOC_W*PW-1:0]   alloc_preg;
    logic [FREE_W-1:0]       free_vld;
    logic [FREE_W*PW-1:0]    free_preg;
    logic                    ckpt_take;
    logic [CW-1:0]           ckpt_id;
    logic                    ckpt_full;
    logic                    ckpt_release;
    logic                    ckpt_restore;
    logic [CW-1:0]           restore_id;
    logic [PW:0]             count;
    logic                    empty;
    logic                    err;

    modport master (
        output stall, alloc_req, free_vld, free_preg, ckpt_take,
               ckpt_release, ckpt_restore, restore_id,
        input  alloc_grant, alloc_preg, ckpt_id, ckpt_full, count, empty, err
    );

    modport slave (
        input  stall, alloc_req, free_vld, free_preg, ckpt_take,
               ckpt_release, ckpt_restore, restore_id,
        output alloc_grant, alloc_preg, ckpt_id, ckpt_full, count, empty, err
    );
endinterface
`default_nettype wire

// File: rtl/free_preg_list_mw.sv
`default_nettype none
//============================================================================
// Module      : free_preg_list_mw
// Description : Multi-wide free physical-register list with branch
//               checkpoints. Hands out up to ALLOC_W pregs per cycle
//               (all-or-nothing), accepts up to FREE_W retired pregs per
//               cycle, and keeps an in-order FIFO of head snapshots for
//               single-cycle mispredict recovery.
//               clk   : rising-edge clock
//               rst_n : asynchronous active-low reset
//               bus   : free_preg_list_mw_if slave modport
// Revision    : 1.0 - initial release
//============================================================================
module free_preg_list_mw #(
    parameter int NUM_PREGS = 128,
    parameter int NUM_AREGS = 32,
    parameter int ALLOC_W   = 2,
    parameter int FREE_W    = 2,
    parameter int NUM_CKPT  = 4
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    free_preg_list_mw_if.slave  bus
);
    localparam int PW = $clog2(NUM_PREGS);
    localparam int CW = $clog2(NUM_CKPT);
    localparam int c_INIT_CNT = NUM_PREGS - NUM_AREGS;
    localparam logic [PW:0]   c_TAIL_INIT = (PW+1)'(c_INIT_CNT);
    localparam logic [PW+1:0] c_MAX_CNT   = (PW+2)'(NUM_PREGS);
    localparam logic [CW:0]   c_CKPT_MAX  = (CW+1)'(NUM_CKPT);

    logic [PW-1:0] r_mem  [NUM_PREGS];
    logic [PW:0]   r_slot [NUM_CKPT];
    logic [PW:0]   r_head, r_tail;
    logic [CW:0]   r_ck_head, r_ck_tail;
    logic          r_err;

    logic [PW:0]   w_count, w_n_alloc, w_n_free, w_head_next;
    logic [PW-1:0] w_free_idx [FREE_W];
    logic [PW+1:0] w_free_sum;
    logic          w_free_ovf, w_free_fire;
    logic          w_grant, w_alloc_fire;
    logic [CW:0]   w_ck_cnt, w_ck_head_next, w_ck_tail_next;
    logic [CW-1:0] w_rst_off;
    logic          w_ck_full, w_rst_live, w_restore;
    logic          w_take_fire, w_take_err, w_err_evt;

    // Lane popcounts; each valid free lane lands at tail + (valid lanes below it)
    always_comb begin
        w_n_alloc = '0;
        for (int i = 0; i < ALLOC_W; i++)
            w_n_alloc = w_n_alloc + {{PW{1'b0}}, bus.alloc_req[i]};
        w_n_free = '0;
        for (int k = 0; k < FREE_W; k++) begin
            w_free_idx[k] = r_tail[PW-1:0] + w_n_free[PW-1:0];
            w_n_free      = w_n_free + {{PW{1'b0}}, bus.free_vld[k]};
        end
    end

    assign w_count      = r_tail - r_head;
    // Grant looks only at the pre-free count; an empty request is never granted
    assign w_grant      = (|bus.alloc_req) && (w_count >= w_n_alloc);
    assign w_alloc_fire = w_grant && !bus.stall && !bus.ckpt_restore;

    // A free batch that would push the list past NUM_PREGS is dropped whole
    assign w_free_sum   = {1'b0, w_count} + {1'b0, w_n_free};
    assign w_free_ovf   = w_free_sum > c_MAX_CNT;
    assign w_free_fire  = !w_free_ovf;

    // Checkpoint FIFO occupancy and liveness of the slot being restored:
    // a slot is live when its distance from the oldest is below occupancy
    assign w_ck_cnt    = r_ck_tail - r_ck_head;
    assign w_ck_full   = (w_ck_cnt == c_CKPT_MAX);
    assign w_rst_off   = bus.restore_id - r_ck_head[CW-1:0];
    assign w_rst_live  = ({1'b0, w_rst_off} < w_ck_cnt);
    assign w_restore   = bus.ckpt_restore && w_rst_live;

    assign w_take_fire = bus.ckpt_take && !bus.stall && !bus.ckpt_restore && !w_ck_full;
    assign w_take_err  = bus.ckpt_take && !bus.stall && !bus.ckpt_restore &&  w_ck_full;
    assign w_err_evt   = (w_free_ovf && (|bus.free_vld)) || w_take_err ||
                         (bus.ckpt_restore && !w_rst_live);

    always_comb begin
        w_head_next = r_head;
        if (w_restore)
            w_head_next = r_slot[bus.restore_id];
        else if (w_alloc_fire)
            w_head_next = r_head + w_n_alloc;
    end

    always_comb begin
        w_ck_head_next = r_ck_head;
        w_ck_tail_next = r_ck_tail;
        if (w_restore) begin
            // Drop the restored slot and every younger one
            w_ck_tail_next = r_ck_head + {1'b0, w_rst_off};
        end else begin
            if (bus.ckpt_release && !bus.ckpt_restore && (w_ck_cnt != '0))
                w_ck_head_next = r_ck_head + 1'b1;
            if (w_take_fire)
                w_ck_tail_next = r_ck_tail + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head    <= '0;
            r_tail    <= c_TAIL_INIT;
            r_ck_head <= '0;
            r_ck_tail <= '0;
            r_err     <= 1'b0;
        end else begin
            r_head    <= w_head_next;
            if (w_free_fire)
                r_tail <= r_tail + w_n_free;
            r_ck_head <= w_ck_head_next;
            r_ck_tail <= w_ck_tail_next;
            if (w_err_evt)
                r_err <= 1'b1;
        end
    end

    // Snapshot is the head after this cycle's allocation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NUM_CKPT; s++)
                r_slot[s] <= '0;
        end else if (w_take_fire) begin
            r_slot[r_ck_tail[CW-1:0]] <= w_head_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_PREGS; i++)
                r_mem[i] <= (i < c_INIT_CNT) ? PW'(NUM_AREGS + i) : '0;
        end else if (w_free_fire) begin
            for (int k = 0; k < FREE_W; k++)
                if (bus.free_vld[k])
                    r_mem[w_free_idx[k]] <= bus.free_preg[k*PW +: PW];
        end
    end

    generate
        for (genvar g = 0; g < ALLOC_W; g++) begin : g_alloc_lane
            assign bus.alloc_preg[g*PW +: PW] = r_mem[r_head[PW-1:0] + PW'(g)];
        end
    endgenerate

    assign bus.alloc_grant = w_grant;
    assign bus.count       = w_count;
    assign bus.empty       = (w_count == '0);
    assign bus.ckpt_id     = r_ck_tail[CW-1:0];
    assign bus.ckpt_full   = w_ck_full;
    assign bus.err         = r_err;

endmodule
`default_nettype wire
